// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage multi-cycle integer divider.
// Holds the FSM encoding, handshake levels and the operand magnitude helper.
package div_unit_pkg;

    localparam int REG_DATA_BUS        = 32;
    localparam int DOUBLE_REG_DATA_BUS = 64;
    localparam logic [REG_DATA_BUS-1:0] ZEROWORD = '0;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_t;

    // Two's-complement negate when requested; used for |operand| and sign fix-up.
    function automatic logic [REG_DATA_BUS-1:0] cond_negate(
        input logic [REG_DATA_BUS-1:0] value,
        input logic                    negate
    );
        return negate ? (~value + 1'b1) : value;
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
// EX holds start until it has consumed ready; annul aborts an operation in flight.
interface div_unit_if;
    import div_unit_pkg::*;

    logic                           signed_div;
    logic [REG_DATA_BUS-1:0]        opdata1;
    logic [REG_DATA_BUS-1:0]        opdata2;
    logic                           start;
    logic                           annul;
    logic [DOUBLE_REG_DATA_BUS-1:0] result;
    logic                           ready;

    modport master (
        output signed_div, opdata1, opdata2, start, annul,
        input  result, ready
    );

    modport slave (
        input  signed_div, opdata1, opdata2, start, annul,
        output result, ready
    );

endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module div_step
    import div_unit_pkg::*;
(
    input  logic [REG_DATA_BUS-1:0] rem,
    input  logic                    next_bit,
    input  logic [REG_DATA_BUS-1:0] divisor,
    output logic [REG_DATA_BUS-1:0] rem_next,
    output logic                    quo_bit
);

    logic [REG_DATA_BUS:0] shifted;
    logic [REG_DATA_BUS:0] trial;

    // rem < divisor keeps the difference inside 33-bit two's-complement range,
    // so bit 32 of the trial is a reliable borrow/sign flag.
    assign shifted  = {rem, next_bit};
    assign trial    = shifted - {1'b0, divisor};
    assign quo_bit  = ~trial[REG_DATA_BUS];
    assign rem_next = quo_bit ? trial[REG_DATA_BUS-1:0] : shifted[REG_DATA_BUS-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit: 32 restoring iterations on operand
// magnitudes, then a sign fix-up producing {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_unit_if.slave      bus
);

    div_state_t                     state_reg, state_next;
    logic [5:0]                     cnt_reg, cnt_next;
    logic [REG_DATA_BUS-1:0]        rem_reg, rem_next;
    logic [REG_DATA_BUS-1:0]        quo_reg, quo_next;
    logic [REG_DATA_BUS-1:0]        divisor_reg, divisor_next;
    logic                           rem_neg_reg, rem_neg_next;
    logic                           quo_neg_reg, quo_neg_next;
    logic [DOUBLE_REG_DATA_BUS-1:0] result_reg, result_next;
    logic                           ready_reg, ready_next;

    logic [REG_DATA_BUS-1:0]        step_rem;
    logic                           step_bit;
    logic                           op1_neg;
    logic                           op2_neg;

    // The dividend sits in quo_reg and is shifted out MSB-first as quotient bits shift in.
    div_step u_step (
        .rem      (rem_reg),
        .next_bit (quo_reg[REG_DATA_BUS-1]),
        .divisor  (divisor_reg),
        .rem_next (step_rem),
        .quo_bit  (step_bit)
    );

    assign op1_neg = bus.signed_div & bus.opdata1[REG_DATA_BUS-1];
    assign op2_neg = bus.signed_div & bus.opdata2[REG_DATA_BUS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= '0;
            rem_reg     <= ZEROWORD;
            quo_reg     <= ZEROWORD;
            divisor_reg <= ZEROWORD;
            rem_neg_reg <= 1'b0;
            quo_neg_reg <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DIV_RESULT_NOT_READY;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rem_reg     <= rem_next;
            quo_reg     <= quo_next;
            divisor_reg <= divisor_next;
            rem_neg_reg <= rem_neg_next;
            quo_neg_reg <= quo_neg_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        rem_next     = rem_reg;
        quo_next     = quo_reg;
        divisor_next = divisor_reg;
        rem_neg_next = rem_neg_reg;
        quo_neg_next = quo_neg_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;

        case (state_reg)
            DIV_FREE: begin
                result_next = '0;
                ready_next  = DIV_RESULT_NOT_READY;
                if (bus.start == DIV_START && !bus.annul) begin
                    if (bus.opdata2 == ZEROWORD) begin
                        state_next = DIV_BY_ZERO;
                    end else begin
                        state_next   = DIV_ON;
                        cnt_next     = '0;
                        rem_next     = ZEROWORD;
                        quo_next     = cond_negate(bus.opdata1, op1_neg);
                        divisor_next = cond_negate(bus.opdata2, op2_neg);
                        rem_neg_next = op1_neg;
                        quo_neg_next = op1_neg ^ op2_neg;
                    end
                end
            end

            DIV_BY_ZERO: begin
                state_next  = DIV_END;
                result_next = '0;
                ready_next  = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (bus.annul) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end else if (cnt_reg != 6'd32) begin
                    rem_next = step_rem;
                    quo_next = {quo_reg[REG_DATA_BUS-2:0], step_bit};
                    cnt_next = cnt_reg + 6'd1;
                end else begin
                    state_next  = DIV_END;
                    result_next = {cond_negate(rem_reg, rem_neg_reg),
                                   cond_negate(quo_reg, quo_neg_reg)};
                    ready_next  = DIV_RESULT_READY;
                end
            end

            DIV_END: begin
                if (bus.start == DIV_STOP) begin
                    state_next  = DIV_FREE;
                    result_next = '0;
                    ready_next  = DIV_RESULT_NOT_READY;
                end
            end

            default: begin
                state_next  = DIV_FREE;
                result_next = '0;
                ready_next  = DIV_RESULT_NOT_READY;
            end
        endcase
    end

    assign bus.result = result_reg;
    assign bus.ready  = ready_reg;

endmodule
